// File: rtl/q_share_arbiter.sv
// q_share_arbiter
//   Round-robin arbiter for NUM_REQ requesters sharing one registered Q net.
//   The grantee's q_in is driven onto q_out. Tenure ends on done, on a req
//   drop, or after HOLD_MAX cycles. A one-cycle turnaround (TURN), with no
//   driver on the net, follows every tenure. A 2-bit shared configuration
//   register can be loaded only while the arbiter is idle.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : per-requester level request
//   done      : per-requester release (only the grantee's bit counts)
//   q_in      : per-requester Q value
//   q_out     : shared net, registered q_in of the grantee, else 0
//   grant     : one-hot or zero grant vector
//   busy      : high in GRANT or TURN
//   timeout   : one-cycle pulse when the tenure limit alone ended a grant
//   cfg_in    : new configuration value
//   cfg_load  : load strobe for cfg_in
//   cfg_out   : registered configuration
//   cfg_err   : one-cycle pulse when a load is rejected (not idle)
//
// state | meaning
// ------+-------------------------------------------------------
// IDLE  | no driver; arbitrate any pending req, accept cfg loads
// GRANT | grantee drives q_out; hold counter running
// TURN  | one-cycle no-overlap turnaround, net forced to 0

module q_share_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  input  logic [NUM_REQ-1:0] q_in,
  output logic               q_out,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               timeout,
  input  logic [1:0]         cfg_in,
  input  logic               cfg_load,
  output logic [1:0]         cfg_out,
  output logic               cfg_err
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               q_out_q, q_out_d;
  logic               timeout_q, timeout_d;
  logic [1:0]         cfg_q, cfg_d;
  logic               cfg_err_q, cfg_err_d;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   cand;

  // Round-robin search starting at ptr_q and wrapping at NUM_REQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    q_out_d   = 1'b0;
    timeout_d = 1'b0;
    cfg_d     = cfg_q;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        hold_d  = '0;
        if (cfg_load) cfg_d = cfg_in;
        if (found) begin
          state_d = GRANT;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
          idx_d   = win;
          ptr_d   = IDX_W'((int'(win) + 1) % NUM_REQ);
          hold_d  = HOLD_W'(1);
          q_out_d = q_in[win];
        end
      end
      GRANT: begin
        if (cfg_load) cfg_err_d = 1'b1;
        if (done[idx_q] || !req[idx_q] || (hold_q == HOLD_W'(HOLD_MAX))) begin
          state_d   = TURN;
          grant_d   = '0;
          hold_d    = '0;
          // Flag only releases forced purely by the tenure limit.
          timeout_d = !done[idx_q] && req[idx_q];
        end else begin
          hold_d  = hold_q + HOLD_W'(1);
          q_out_d = q_in[idx_q];
        end
      end
      TURN: begin
        if (cfg_load) cfg_err_d = 1'b1;
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      q_out_q   <= 1'b0;
      timeout_q <= 1'b0;
      cfg_q     <= 2'b00;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      q_out_q   <= q_out_d;
      timeout_q <= timeout_d;
      cfg_q     <= cfg_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign q_out   = q_out_q;
  assign grant   = grant_q;
  assign busy    = (state_q == GRANT) || (state_q == TURN);
  assign timeout = timeout_q;
  assign cfg_out = cfg_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_q_share_arbiter.sv
module tb_q_share_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // two-requester instance, default tenure limit
  logic [1:0] req2 = '0, done2 = '0, q_in2 = '0, grant2;
  logic       q_out2, busy2, timeout2, cfg_load2 = 1'b0, cfg_err2;
  logic [1:0] cfg_in2 = '0, cfg_out2;

  // three-requester instance, tenure limit 4
  logic [2:0] req3 = '0, done3 = '0, q_in3 = '0, grant3;
  logic       q_out3, busy3, timeout3, cfg_load3 = 1'b0, cfg_err3;
  logic [1:0] cfg_in3 = '0, cfg_out3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  q_share_arbiter #(.NUM_REQ(2), .HOLD_MAX(15)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .done(done2), .q_in(q_in2),
    .q_out(q_out2), .grant(grant2), .busy(busy2), .timeout(timeout2),
    .cfg_in(cfg_in2), .cfg_load(cfg_load2), .cfg_out(cfg_out2), .cfg_err(cfg_err2)
  );

  q_share_arbiter #(.NUM_REQ(3), .HOLD_MAX(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .done(done3), .q_in(q_in3),
    .q_out(q_out3), .grant(grant3), .busy(busy3), .timeout(timeout3),
    .cfg_in(cfg_in3), .cfg_load(cfg_load3), .cfg_out(cfg_out3), .cfg_err(cfg_err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seq2 [3];

  initial begin
    seq2[0] = 2'b10;
    seq2[1] = 2'b01;
    seq2[2] = 2'b10;

    #12 rst_n = 1'b1;
    #1;
    check("rst_grant", grant2, 0);
    check("rst_qout", q_out2, 0);
    check("rst_busy", busy2, 0);
    check("rst_timeout", timeout2, 0);
    check("rst_cfg_err", cfg_err2, 0);
    check("rst_cfg_out", cfg_out2, 0);
    step();

    // cfg load while idle
    cfg_in2 = 2'b11; cfg_load2 = 1'b1;
    step();
    cfg_load2 = 1'b0;
    check("cfg_idle_out", cfg_out2, 3);
    check("cfg_idle_err", cfg_err2, 0);

    // single request, q follows with one-cycle lag
    req2 = 2'b01; q_in2 = 2'b01;
    step();
    check("single_grant", grant2, 2'b01);
    check("single_busy", busy2, 1);
    check("single_q1", q_out2, 1);
    q_in2 = 2'b00;
    step();
    check("single_q0", q_out2, 0);
    q_in2 = 2'b01; done2 = 2'b10;   // non-grantee done is ignored
    step();
    done2 = 2'b00;
    check("nongrantee_done", grant2, 2'b01);
    check("single_q1b", q_out2, 1);
    cfg_in2 = 2'b01; cfg_load2 = 1'b1;
    step();
    cfg_load2 = 1'b0;
    check("cfg_busy_out", cfg_out2, 3);
    check("cfg_busy_err", cfg_err2, 1);
    done2 = 2'b01;
    step();
    done2 = 2'b00; req2 = 2'b00;
    check("cfg_err_pulse", cfg_err2, 0);
    check("turn_grant", grant2, 0);
    check("turn_qout", q_out2, 0);
    check("turn_busy", busy2, 1);
    check("turn_timeout", timeout2, 0);
    step();
    check("idle_busy", busy2, 0);

    // contention: ptr is 1 after granting requester 0
    req2 = 2'b11; q_in2 = 2'b11;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        check("cont_grant", grant2, seq2[i]);
      end
      done2 = seq2[i];
      step();
      done2 = 2'b00;
      check("cont_turn", grant2, 0);
      step();
      check("cont_idle", busy2, 0);
    end

    // exit on req drop; ptr is 0 after last winner 1
    req2 = 2'b01;
    step();
    check("drop_grant", grant2, 2'b01);
    req2 = 2'b00;
    step();
    check("drop_turn", grant2, 0);
    check("drop_timeout", timeout2, 0);
    step();

    // reset mid-grant
    req2 = 2'b01;
    step();
    check("prerst_grant", grant2, 2'b01);
    rst_n = 1'b0;
    #1;
    check("rst_mid_grant", grant2, 0);
    check("rst_mid_qout", q_out2, 0);
    check("rst_mid_cfg", cfg_out2, 0);
    check("rst_mid_busy", busy2, 0);
    req2 = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("postrst_grant", grant2, 2'b01);
    check("postrst_qout", q_out2, 1);
    req2 = 2'b00;
    step();
    step();

    // timeout on three-requester instance, HOLD_MAX 4
    req3 = 3'b010; q_in3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      step();
      check("to_grant", grant3, 3'b010);
      check("to_no_pulse", timeout3, 0);
    end
    step();
    check("to_turn_grant", grant3, 0);
    check("to_pulse", timeout3, 1);
    check("to_turn_qout", q_out3, 0);
    step();
    check("to_idle_pulse", timeout3, 0);
    check("to_idle_grant", grant3, 0);
    step();
    check("to_regrant", grant3, 3'b010);
    req3 = 3'b000;
    step();
    step();

    // wrap: ptr = 2, req = 011 -> requester 0
    req3 = 3'b011;
    step();
    check("wrap_grant", grant3, 3'b001);
    check("wrap_qout", q_out3, 1);
    done3 = 3'b001;
    step();
    done3 = 3'b000;
    check("wrap_turn_to", timeout3, 0);
    step();
    step();
    check("wrap_ptr1", grant3, 3'b010);
    step(); step(); step();
    check("lim_grant", grant3, 3'b010);
    req3 = 3'b000;  // drop coincides with tenure limit
    step();
    check("lim_drop_turn", grant3, 0);
    check("lim_drop_to", timeout3, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/q_share_arbiter.md
Q_SHARE_ARBITER -- requirements
Module: q_share_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, meaning the number of MOD2-style requesters sharing the Q output net (legal 2..4).
REQ-002 The block SHALL have parameter HOLD_MAX, default 15, meaning the maximum grant tenure in cycles before forced release (legal 1..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NUM_REQ  per-requester request to drive the shared net, level-sensitive.
REQ-006 done  input  NUM_REQ  per-requester release; only the bit of the current grantee is honoured.
REQ-007 q_in  input  NUM_REQ  per-requester Q value.
REQ-008 q_out  output  1  the shared net, registered: q_in of the grantee, else 0.
REQ-009 grant  output  NUM_REQ  one-hot or zero grant vector.
REQ-010 busy  output  1  high while in GRANT or TURN.
REQ-011 timeout  output  1  one-cycle pulse on forced release.
REQ-012 cfg_in  input  2  new shared bus1 configuration value.
REQ-013 cfg_load  input  1  request to load cfg_in into cfg_out.
REQ-014 cfg_out  output  2  registered shared bus1 configuration.
REQ-015 cfg_err  output  1  one-cycle pulse when a cfg_load is rejected.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT and TURN.
REQ-017 In IDLE with any req bit set, the block SHALL select a winner round-robin, starting the search at ptr and wrapping from NUM_REQ-1 to 0, and enter GRANT next cycle with grant one-hot on the winner.
REQ-018 ptr SHALL update to (winner+1) mod NUM_REQ on each grant.
REQ-019 The req-to-grant latency from IDLE SHALL be exactly 1 cycle.
REQ-020 In GRANT, q_out SHALL equal q_in[grantee] registered, so it lags q_in by 1 cycle.
REQ-021 In GRANT, a hold counter SHALL count from 1 on the first grant cycle, incrementing each cycle.
REQ-022 GRANT SHALL exit to TURN on done[grantee] = 1, on req[grantee] = 0, or when the counter reaches HOLD_MAX; priority is done, then req drop, then timeout.
REQ-023 timeout SHALL pulse only when the HOLD_MAX limit is the sole exit cause.
REQ-024 TURN SHALL last exactly 1 cycle with grant = 0 and q_out = 0 (no-overlap turnaround), then return to IDLE.
REQ-025 A requester whose req stays high through TURN SHALL be arbitrated normally in IDLE; because of the round-robin pointer it cannot win again while another req is pending.
REQ-026 done bits of non-grantees SHALL be ignored.
REQ-027 Simultaneous done[grantee] and a new req from another requester SHALL give TURN, then a grant to the other requester.
REQ-028 A cfg_load in IDLE SHALL update cfg_out on the next edge.
REQ-029 A cfg_load in GRANT or TURN SHALL leave cfg_out unchanged and pulse cfg_err; loads in those states are never deferred.
REQ-030 A cfg_load in IDLE that coincides with a new grant decision SHALL be accepted.
REQ-031 grant SHALL never have more than one bit set; q_out SHALL be 0 whenever grant = 0.

Reset
REQ-032 Asserting rst_n low SHALL immediately force:
- state IDLE;
- grant = 0, q_out = 0, busy = 0, timeout = 0, cfg_err = 0;
- cfg_out = 2'b00, ptr = 0, hold counter = 0.
REQ-033 Reset asserted mid-grant SHALL drop grant asynchronously with no TURN cycle.
REQ-034 After rst_n deasserts, the first arbitration SHALL take place on the first rising edge at which rst_n is high.

Verification
REQ-035 Single request: req = 01 held, q_in[0] toggling, done[0] pulsed at cycle 5 -> grant = 01 from cycle 1, q_out follows q_in[0] with 1-cycle lag, TURN at cycle 6, grant = 00.
REQ-036 Contention: req = 11 held constantly, done pulsed by each grantee after 3 cycles -> grants alternate 01, 10, 01; each grant is separated by TURN plus IDLE; never two bits set.
REQ-037 Timeout: HOLD_MAX = 4, req = 10 held, no done -> grant = 10 for exactly 4 cycles, timeout pulses once, then re-grant to requester 1 after IDLE.
REQ-038 Config: cfg_load with cfg_in = 11 in IDLE -> cfg_out = 11; cfg_load with cfg_in = 01 during GRANT -> cfg_out stays 11 and cfg_err pulses once.
REQ-039 Reset mid-grant: rst_n low while grant = 01 -> grant, q_out and cfg_out are 0 in the same cycle; after release with req = 10, grant = 10 (ptr = 0, search from 0 finds requester 1).
REQ-040 Wrap-around: NUM_REQ = 3, ptr = 2, req = 011 -> requester 0 wins and ptr becomes 1.
